// File: rtl/alu_control_unit.sv
// Sequencer for the A/Q/M ALU datapath: single-cycle ops, Booth radix-2 multiply and
// restoring divide. One-hot state register; the control word is decoded from state.
module alu_control_unit #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = 5
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [3:0]       i_op,
   input  logic             i_q0,
   input  logic             i_q_m1,
   input  logic             i_a_msb,
   input  logic             i_m_zero,
   output logic [8:0]       o_c,
   output logic             o_busy,
   output logic             o_ack,
   output logic             o_err,
   output logic [CNT_W-1:0] o_cnt
);

   typedef enum logic [10:0] {
      StIdle   = 11'b000_0000_0001,
      StLoad   = 11'b000_0000_0010,
      StArith  = 11'b000_0000_0100,
      StMtest  = 11'b000_0000_1000,
      StMshift = 11'b000_0001_0000,
      StDchk   = 11'b000_0010_0000,
      StDshift = 11'b000_0100_0000,
      StDsub   = 11'b000_1000_0000,
      StDtest  = 11'b001_0000_0000,
      StOut    = 11'b010_0000_0000,
      StDone   = 11'b100_0000_0000
   } state_e;

   localparam int unsigned CLoad  = 0;
   localparam int unsigned CAdd   = 1;
   localparam int unsigned CSub   = 2;
   localparam int unsigned CLogic = 3;
   localparam int unsigned CAshr  = 4;
   localparam int unsigned CShl   = 5;
   localparam int unsigned CSetq0 = 6;
   localparam int unsigned COutLo = 7;
   localparam int unsigned COutHi = 8;

   state_e           r_state;
   state_e           w_state_d;
   logic [3:0]       r_op;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_d;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             r_err;
   logic             w_err_d;
   logic             w_last;
   logic             w_wide_op;

   assign w_cnt_inc = r_cnt + CNT_W'(1);
   assign w_last    = (w_cnt_inc == CNT_W'(WIDTH));
   assign w_wide_op = (r_op == 4'd6) || (r_op == 4'd7);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_op    <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         r_err   <= w_err_d;
         if ((r_state == StIdle) && i_start) begin
            r_op <= i_op;
         end
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      w_err_d   = r_err;
      o_c       = '0;
      unique case (r_state)
         StIdle: begin
            w_err_d = 1'b0;
            if (i_start) w_state_d = StLoad;
         end
         StLoad: begin
            o_c[CLoad] = 1'b1;
            w_cnt_d    = '0;
            if (r_op[3]) begin
               w_err_d   = 1'b1;
               w_state_d = StDone;
            end else if (r_op == 4'd6) begin
               w_state_d = StMtest;
            end else if (r_op == 4'd7) begin
               w_state_d = StDchk;
            end else begin
               w_state_d = StArith;
            end
         end
         StArith: begin
            case (r_op)
               4'd0:    o_c[CAdd]   = 1'b1;
               4'd1:    o_c[CSub]   = 1'b1;
               default: o_c[CLogic] = 1'b1;
            endcase
            w_state_d = StOut;
         end
         // Booth pair decode: 10 subtracts M, 01 adds M, 00/11 only shift.
         StMtest: begin
            case ({i_q0, i_q_m1})
               2'b10:   o_c[CSub] = 1'b1;
               2'b01:   o_c[CAdd] = 1'b1;
               default: ;
            endcase
            w_state_d = StMshift;
         end
         StMshift: begin
            o_c[CAshr] = 1'b1;
            w_cnt_d    = w_cnt_inc;
            w_state_d  = w_last ? StOut : StMtest;
         end
         StDchk: begin
            if (i_m_zero) begin
               w_err_d   = 1'b1;
               w_state_d = StDone;
            end else begin
               w_state_d = StDshift;
            end
         end
         StDshift: begin
            o_c[CShl] = 1'b1;
            w_state_d = StDsub;
         end
         StDsub: begin
            o_c[CSub] = 1'b1;
            w_state_d = StDtest;
         end
         // Negative remainder means the trial subtract failed: restore A, leave Q[0]=0.
         StDtest: begin
            if (i_a_msb) o_c[CAdd] = 1'b1;
            else         o_c[CSetq0] = 1'b1;
            w_cnt_d   = w_cnt_inc;
            w_state_d = w_last ? StOut : StDshift;
         end
         StOut: begin
            o_c[COutLo] = 1'b1;
            o_c[COutHi] = w_wide_op;
            w_state_d   = StDone;
         end
         StDone: begin
            w_state_d = StIdle;
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   assign o_busy = (r_state != StIdle);
   assign o_ack  = (r_state == StDone);
   assign o_err  = o_ack & r_err;
   assign o_cnt  = r_cnt;

endmodule

// File: tb/tb_alu_control_unit.sv
// Bench for alu_control_unit: behavioural A/Q/M datapath driven by the control word,
// expected results queued at issue time and checked by a monitor on every ack.
module tb_alu_control_unit;
   localparam int unsigned WIDTH = 16;
   localparam int unsigned CNT_W = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [3:0]       op;
   logic             q0;
   logic             q_m1;
   logic             a_msb;
   logic             m_zero;
   logic [8:0]       c;
   logic             busy;
   logic             ack;
   logic             err;
   logic [CNT_W-1:0] cnt;

   logic [15:0] dp_a = '0, dp_q = '0, dp_m = '0;
   logic        dp_qm1 = 1'b0;
   logic [15:0] op1 = '0, op2 = '0;
   logic [3:0]  dp_op = '0;
   logic [8:0]  c_s = '0;

   int total = 0;
   int bad = 0;
   int n_done = 0;
   int n_exp = 0;

   typedef struct {
      string       nm;
      int          lat;
      logic [31:0] err;
      logic [15:0] a, q;
      int          n_add, n_sub, n_log, n_shr, n_shl, n_setq, n_hi;
      logic [8:0]  c1, c2, c3;
      int          cnt;
   } exp_t;

   exp_t exp_q[$];

   alu_control_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_start  (start),
      .i_op     (op),
      .i_q0     (q0),
      .i_q_m1   (q_m1),
      .i_a_msb  (a_msb),
      .i_m_zero (m_zero),
      .o_c      (c),
      .o_busy   (busy),
      .o_ack    (ack),
      .o_err    (err),
      .o_cnt    (cnt)
   );

   always #5 clk = ~clk;

   assign q0     = dp_q[0];
   assign q_m1   = dp_qm1;
   assign a_msb  = dp_a[15];
   assign m_zero = (dp_m == 16'd0);

   // Datapath applies the control word sampled on the preceding falling edge.
   always @(posedge clk) begin
      if (c_s[0]) begin
         dp_a <= '0; dp_m <= op1; dp_q <= op2; dp_qm1 <= 1'b0;
      end
      if (c_s[1]) dp_a <= dp_a + dp_m;
      if (c_s[2]) dp_a <= dp_a - dp_m;
      if (c_s[3]) begin
         case (dp_op)
            4'd2:    dp_a <= dp_m & dp_q;
            4'd3:    dp_a <= dp_m | dp_q;
            4'd4:    dp_a <= dp_m ^ dp_q;
            4'd5:    dp_a <= ~dp_m;
            default: dp_a <= dp_a;
         endcase
      end
      if (c_s[4]) begin
         dp_a <= {dp_a[15], dp_a[15:1]}; dp_q <= {dp_a[0], dp_q[15:1]}; dp_qm1 <= dp_q[0];
      end
      if (c_s[5]) begin
         dp_a <= {dp_a[14:0], dp_q[15]}; dp_q <= {dp_q[14:0], 1'b0};
      end
      if (c_s[6]) dp_q[0] <= 1'b1;
   end

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, want);
      end
   endfunction

   task automatic push_exp(input string nm, input int lat, input logic [31:0] e_err,
                           input logic [15:0] a, input logic [15:0] q,
                           input int nadd, input int nsub, input int nlog, input int nshr,
                           input int nshl, input int nsetq, input int nhi,
                           input logic [8:0] c1, input logic [8:0] c2, input logic [8:0] c3,
                           input int ecnt);
      exp_t e;
      e.nm = nm; e.lat = lat; e.err = e_err; e.a = a; e.q = q;
      e.n_add = nadd; e.n_sub = nsub; e.n_log = nlog; e.n_shr = nshr;
      e.n_shl = nshl; e.n_setq = nsetq; e.n_hi = nhi;
      e.c1 = c1; e.c2 = c2; e.c3 = c3; e.cnt = ecnt;
      exp_q.push_back(e);
      n_exp++;
   endtask

   // Monitor: tracks the in-flight operation and checks it when ack appears.
   initial begin
      bit         inflight = 0;
      int         cyc = 0;
      int         m_add = 0, m_sub = 0, m_log = 0, m_shr = 0, m_shl = 0, m_setq = 0, m_hi = 0;
      logic [8:0] tr1 = '0, tr2 = '0, tr3 = '0;
      exp_t       e;
      forever begin
         @(negedge clk);
         c_s = c;
         if (rst) begin
            inflight = 0;
         end else begin
            if (inflight) begin
               cyc++;
               if (cyc == 1) tr1 = c;
               if (cyc == 2) tr2 = c;
               if (cyc == 3) tr3 = c;
               if (c[1]) m_add++;
               if (c[2]) m_sub++;
               if (c[3]) m_log++;
               if (c[4]) m_shr++;
               if (c[5]) m_shl++;
               if (c[6]) m_setq++;
               if (c[8]) m_hi++;
               if (ack) begin
                  if (exp_q.size() == 0) begin
                     chk("ack_expected", 32'(ack), 32'd0);
                  end else begin
                     e = exp_q.pop_front();
                     chk({e.nm, "_lat"}, cyc, e.lat);
                     chk({e.nm, "_err"}, 32'(err), e.err);
                     chk({e.nm, "_cnt"}, 32'(cnt), e.cnt);
                     chk({e.nm, "_c1"}, 32'(tr1), 32'(e.c1));
                     if (e.lat >= 3) chk({e.nm, "_c2"}, 32'(tr2), 32'(e.c2));
                     if (e.lat >= 4) chk({e.nm, "_c3"}, 32'(tr3), 32'(e.c3));
                     chk({e.nm, "_nadd"}, m_add, e.n_add);
                     chk({e.nm, "_nsub"}, m_sub, e.n_sub);
                     chk({e.nm, "_nlog"}, m_log, e.n_log);
                     chk({e.nm, "_nshr"}, m_shr, e.n_shr);
                     chk({e.nm, "_nshl"}, m_shl, e.n_shl);
                     chk({e.nm, "_nsetq"}, m_setq, e.n_setq);
                     chk({e.nm, "_nhi"}, m_hi, e.n_hi);
                     chk({e.nm, "_A"}, 32'(dp_a), 32'(e.a));
                     chk({e.nm, "_Q"}, 32'(dp_q), 32'(e.q));
                  end
                  n_done++;
                  inflight = 0;
               end
            end else begin
               chk("idle_ack", 32'(ack), 32'd0);
            end
            if (!busy && start) begin
               inflight = 1; cyc = 0; dp_op = op;
               m_add = 0; m_sub = 0; m_log = 0; m_shr = 0; m_shl = 0; m_setq = 0; m_hi = 0;
            end
         end
      end
   end

   task automatic issue(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
      op = o; op1 = a; op2 = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int target);
      for (int i = 0; i < 200 && n_done < target; i++) begin
         @(posedge clk); #1;
      end
      chk("ack_arrived", n_done, target);
   endtask

   task automatic chk_quiet(input string nm);
      chk({nm, "_c"}, 32'(c), 32'd0);
      chk({nm, "_busy"}, 32'(busy), 32'd0);
      chk({nm, "_ack"}, 32'(ack), 32'd0);
      chk({nm, "_err"}, 32'(err), 32'd0);
      chk({nm, "_cnt"}, 32'(cnt), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit found;
      rst = 1'b1; start = 1'b0; op = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_quiet("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Single-cycle operations
      push_exp("add", 4, 0, 16'h0005, 16'h0009, 1, 0, 0, 0, 0, 0, 0, 9'h001, 9'h002, 9'h080, 0);
      issue(4'd0, 16'h0005, 16'h0009); wait_done(n_exp);
      push_exp("sub", 4, 0, 16'hFFFB, 16'h0009, 0, 1, 0, 0, 0, 0, 0, 9'h001, 9'h004, 9'h080, 0);
      issue(4'd1, 16'h0005, 16'h0009); wait_done(n_exp);
      push_exp("and", 4, 0, 16'h000F, 16'h00FF, 0, 0, 1, 0, 0, 0, 0, 9'h001, 9'h008, 9'h080, 0);
      issue(4'd2, 16'h0F0F, 16'h00FF); wait_done(n_exp);
      push_exp("or", 4, 0, 16'h0FF0, 16'h00F0, 0, 0, 1, 0, 0, 0, 0, 9'h001, 9'h008, 9'h080, 0);
      issue(4'd3, 16'h0F00, 16'h00F0); wait_done(n_exp);
      push_exp("not", 4, 0, 16'hFF00, 16'h1234, 0, 0, 1, 0, 0, 0, 0, 9'h001, 9'h008, 9'h080, 0);
      issue(4'd5, 16'h00FF, 16'h1234); wait_done(n_exp);

      // 3 * -5 = -15
      push_exp("mul", 35, 0, 16'hFFFF, 16'hFFF1, 1, 2, 0, 16, 0, 0, 1, 9'h001, 9'h004, 9'h010, 16);
      issue(4'd6, 16'h0003, 16'hFFFB); wait_done(n_exp);

      // 100 / 7 = 14 r 2
      push_exp("div", 52, 0, 16'h0002, 16'h000E, 13, 16, 0, 0, 16, 3, 1, 9'h001, 9'h000, 9'h020, 16);
      issue(4'd7, 16'h0007, 16'h0064); wait_done(n_exp);

      push_exp("div0", 3, 1, 16'h0000, 16'h0064, 0, 0, 0, 0, 0, 0, 0, 9'h001, 9'h000, 9'h000, 0);
      issue(4'd7, 16'h0000, 16'h0064); wait_done(n_exp);
      push_exp("illegal", 2, 1, 16'h0000, 16'h0066, 0, 0, 0, 0, 0, 0, 0, 9'h001, 9'h000, 9'h000, 0);
      issue(4'd12, 16'h0055, 16'h0066); wait_done(n_exp);
      @(posedge clk); #1;
      chk_quiet("after_err");

      // Abort a multiply in MSHIFT at cnt=7; no ack may follow
      issue(4'd6, 16'h0003, 16'hFFFB);
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (c[4] && cnt == CNT_W'(7)) found = 1;
         else begin
            @(posedge clk); #1;
         end
      end
      chk("reach_mshift_cnt7", 32'(found), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk_quiet("abort");
      repeat (5) @(posedge clk);
      #1;
      push_exp("add2", 4, 0, 16'h1234, 16'h0001, 1, 0, 0, 0, 0, 0, 0, 9'h001, 9'h002, 9'h080, 0);
      issue(4'd0, 16'h1234, 16'h0001); wait_done(n_exp);

      // start held through a multiply; op changed while busy starts an ADD after DONE
      push_exp("mul_held", 35, 0, 16'hFFFF, 16'hFFF1, 2, 2, 0, 16, 0, 0, 1, 9'h001, 9'h004, 9'h010, 16);
      push_exp("add_held", 4, 0, 16'h0007, 16'h0003, 1, 0, 0, 0, 0, 0, 0, 9'h001, 9'h002, 9'h080, 0);
      op = 4'd6; op1 = 16'hFFFD; op2 = 16'h0005; start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      op = 4'd0; op1 = 16'h0007; op2 = 16'h0003;
      wait_done(n_exp - 1);
      chk("gap_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk("restart_busy", 32'(busy), 32'd1);
      start = 1'b0;
      wait_done(n_exp);

      repeat (3) @(posedge clk);
      #1;
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
